mw8080_io_hub: RTL

//  Parametrised I/O and timing hub for Midway-8080-class cores (Space Invaders family and derivatives).

---
 rtl/mw8080_io_hub_if.sv | 23 ++
 rtl/mw8080_io_hub.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mw8080_io_hub_if.sv
// CPU-side I/O bus between a tv80 (Mode 2) core and mw8080_io_hub.
// The master modport is the CPU side; the slave modport is the hub.
interface mw8080_io_hub_if;
    logic [7:0] cpu_addr;
    logic       cpu_iorq_n;
    logic       cpu_rd_n;
    logic       cpu_wr_n;
    logic       cpu_m1_n;
    logic [7:0] cpu_dout;
    logic       cpu_cen;
    logic       int_n;
    logic [7:0] io_din;

    modport master (
        output cpu_addr, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_dout,
        input  cpu_cen, int_n, io_din
    );

    modport slave (
        input  cpu_addr, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_dout,
        output cpu_cen, int_n, io_din
    );
endinterface

// File: rtl/mw8080_io_hub.sv
// I/O and timing hub for Midway-8080-class cores: CPU clock enable, pause, scanline RST
// interrupts, input mux, shift register and sound latches. Define MW_WATCHDOG_EN for the watchdog.
module mw8080_io_hub #(
    parameter int unsigned CEN_DIV     = 10,
    parameter int unsigned NUM_IN      = 3,
    parameter int unsigned SHIFT_W     = 16,
    parameter int unsigned IRQ_LINE_A  = 96,
    parameter int unsigned IRQ_LINE_B  = 224,
    parameter logic [7:0]  VEC_A       = 8'hCF,
    parameter logic [7:0]  VEC_B       = 8'hD7,
    parameter logic [7:0]  PORT_SHAMT  = 8'd2,
    parameter logic [7:0]  PORT_SHDATA = 8'd4,
    parameter logic [7:0]  PORT_SHRD   = 8'd3,
    parameter logic [7:0]  PORT_SND_A  = 8'd3,
    parameter logic [7:0]  PORT_SND_B  = 8'd5,
    parameter logic [7:0]  PORT_WDOG   = 8'd6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause_btn,
    input  logic                menu_visible,
    input  logic [9:0]          y_count,
    input  logic [8*NUM_IN-1:0] in_ports,
    mw8080_io_hub_if.slave      bus,
    output logic [7:0]          snd_a,
    output logic [7:0]          snd_b,
    output logic [7:0]          snd_a_rise,
    output logic [7:0]          snd_b_rise,
    output logic                paused,
    output logic                cpu_rst_req
);

    localparam int unsigned DivW   = $clog2(CEN_DIV);
    localparam int unsigned ShamtW = $clog2(SHIFT_W - 7);
    localparam int unsigned ShMax  = SHIFT_W - 8;

    // ---------------------------------------------------------------- pause control
    logic [2:0] pb_sync_q;
    logic [2:0] mv_sync_q;
    logic       pb_prev_q;
    logic       pause_tgl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_sync_q   <= '0;
            mv_sync_q   <= '0;
            pb_prev_q   <= 1'b0;
            pause_tgl_q <= 1'b0;
        end else begin
            pb_sync_q <= {pb_sync_q[1:0], pause_btn};
            mv_sync_q <= {mv_sync_q[1:0], menu_visible};
            pb_prev_q <= pb_sync_q[2];
            if (pb_sync_q[2] && !pb_prev_q) begin
                pause_tgl_q <= ~pause_tgl_q;
            end
        end
    end

    assign paused = pause_tgl_q | mv_sync_q[2];

    // ---------------------------------------------------------------- clock enable
    logic [DivW-1:0] div_q;
    logic            cen_q;
    logic            div_wrap;

    assign div_wrap = (div_q == DivW'(CEN_DIV - 1));

    // Gating the enable (not the divider) stops the CPU on a whole-cycle boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cen_q <= 1'b0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + 1'b1;
            cen_q <= div_wrap & ~paused;
        end
    end

    assign bus.cpu_cen = cen_q;

    // ---------------------------------------------------------------- bus decode
    logic io_wr;
    logic io_rd;
    logic ack;

    assign io_wr = cen_q & ~bus.cpu_iorq_n & ~bus.cpu_wr_n & bus.cpu_m1_n;
    assign io_rd = ~bus.cpu_iorq_n & ~bus.cpu_rd_n & bus.cpu_m1_n;
    assign ack   = ~bus.cpu_iorq_n & ~bus.cpu_m1_n;

    // ---------------------------------------------------------------- shift register
    logic [SHIFT_W-1:0] shreg_q;
    logic [ShamtW-1:0]  shamt_q;
    logic [ShamtW-1:0]  shamt_d;
    logic [7:0]         sh_res;

    always_comb begin
        shamt_d = ShamtW'(bus.cpu_dout);
        if (bus.cpu_dout > 8'(ShMax)) begin
            shamt_d = ShamtW'(ShMax);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            shamt_q <= '0;
        end else if (io_wr) begin
            if (bus.cpu_addr == PORT_SHDATA) begin
                shreg_q <= {bus.cpu_dout, shreg_q[SHIFT_W-1:8]};
            end
            if (bus.cpu_addr == PORT_SHAMT) begin
                shamt_q <= shamt_d;
            end
        end
    end

    // Byte whose top bit sits shamt bits below the register MSB.
    assign sh_res = 8'(shreg_q >> (ShamtW'(ShMax) - shamt_q));

    // ---------------------------------------------------------------- sound latches
    logic [7:0] snd_a_q;
    logic [7:0] snd_b_q;
    logic [7:0] snd_a_rise_q;
    logic [7:0] snd_b_rise_q;
    logic       wr_snd_a;
    logic       wr_snd_b;

    assign wr_snd_a = io_wr & (bus.cpu_addr == PORT_SND_A);
    assign wr_snd_b = io_wr & (bus.cpu_addr == PORT_SND_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_a_q      <= '0;
            snd_b_q      <= '0;
            snd_a_rise_q <= '0;
            snd_b_rise_q <= '0;
        end else begin
            snd_a_rise_q <= wr_snd_a ? (bus.cpu_dout & ~snd_a_q) : 8'h00;
            snd_b_rise_q <= wr_snd_b ? (bus.cpu_dout & ~snd_b_q) : 8'h00;
            if (wr_snd_a) begin
                snd_a_q <= bus.cpu_dout;
            end
            if (wr_snd_b) begin
                snd_b_q <= bus.cpu_dout;
            end
        end
    end

    assign snd_a      = snd_a_q;
    assign snd_b      = snd_b_q;
    assign snd_a_rise = snd_a_rise_q;
    assign snd_b_rise = snd_b_rise_q;

    // ---------------------------------------------------------------- scanline interrupts
    typedef enum logic [0:0] {StIdle, StPend} irq_st_e;

    irq_st_e    irq_st_q;
    irq_st_e    irq_st_d;
    logic [9:0] y_q;
    logic [7:0] vec_q;
    logic       ev_a;
    logic       ev_b;
    logic       ev;

    assign ev_a = (y_count == 10'(IRQ_LINE_A)) && (y_q != 10'(IRQ_LINE_A));
    assign ev_b = (y_count == 10'(IRQ_LINE_B)) && (y_q != 10'(IRQ_LINE_B));
    assign ev   = (ev_a | ev_b) & ~paused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_st_q <= StIdle;
        end else begin
            irq_st_q <= irq_st_d;
        end
    end

    // A new line event outranks an acknowledge on the same clk.
    always_comb begin
        irq_st_d = irq_st_q;
        unique case (irq_st_q)
            StIdle: if (ev) irq_st_d = StPend;
            StPend: if (!ev && ack) irq_st_d = StIdle;
            default: irq_st_d = StIdle;
        endcase
    end

    always_comb begin
        bus.int_n = (irq_st_q != StPend);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            vec_q <= VEC_A;
        end else begin
            y_q <= y_count;
            if (ev) begin
                vec_q <= ev_b ? VEC_B : VEC_A;
            end
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        bus.io_din = 8'h00;
        if (ack) begin
            bus.io_din = vec_q;
        end else if (io_rd) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (bus.cpu_addr == 8'(k)) begin
                    bus.io_din = in_ports[8*k +: 8];
                end
            end
            if (bus.cpu_addr == PORT_SHRD) begin
                bus.io_din = sh_res;
            end
        end
    end

    // ---------------------------------------------------------------- watchdog
    logic wd_kick;

    assign wd_kick = io_wr & (bus.cpu_addr == PORT_WDOG);

`ifdef MW_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       wd_rst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_rst_q <= 1'b0;
        end else begin
            wd_rst_q <= 1'b0;
            if (wd_kick) begin
                wd_cnt_q <= '0;
            end else if (ev_b && !paused) begin
                if (wd_cnt_q == 8'd254) begin
                    wd_cnt_q <= '0;
                    wd_rst_q <= 1'b1;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 8'd1;
                end
            end
        end
    end

    assign cpu_rst_req = wd_rst_q;
`else
    // Kick decode stays in place so both builds share the same port map.
    assign cpu_rst_req = 1'b0 & wd_kick;
`endif

endmodule
